// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with sideband that tracks upstream through bubbles.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int SIDE_W = 33,
    parameter logic [SIDE_W-1:0] RESET_SIDE = 33'h0_0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    output logic [15:0]       stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state;
    logic acc, dlv;
    assign acc = in_valid & in_ready;
    assign dlv = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
    logic              in_ready_r;
    logic [DATA_W-1:0] skid_data;
    logic [SIDE_W-1:0] skid_side;
    assign in_ready = in_ready_r;
`else
    assign in_ready = !out_valid | out_ready;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= RESET_SIDE;
            stall_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_r <= 1'b1;
            skid_data  <= '0;
            skid_side  <= '0;
`endif
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            // Whenever main is empty the sideband follows upstream so EPC stays correct.
            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_side  <= in_side;
`ifdef PIPE_STAGE_SKID_EN
                in_ready_r <= 1'b1;
`endif
            end else begin
                case (state)
                    EMPTY: begin
                        out_valid <= acc;
                        out_data  <= acc ? in_data : '0;
                        out_side  <= in_side;
                        state     <= acc ? ONE : EMPTY;
                    end
                    ONE: begin
                        if (acc && dlv) begin
                            out_data <= in_data;
                            out_side <= in_side;
                        end else if (dlv) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_side  <= in_side;
                            state     <= EMPTY;
                        end
`ifdef PIPE_STAGE_SKID_EN
                        else if (acc) begin
                            skid_data  <= in_data;
                            skid_side  <= in_side;
                            in_ready_r <= 1'b0;
                            state      <= TWO;
                        end
`endif
                    end
`ifdef PIPE_STAGE_SKID_EN
                    TWO: if (dlv) begin
                        out_data   <= skid_data;
                        out_side   <= skid_side;
                        in_ready_r <= 1'b1;
                        state      <= ONE;
                    end
`endif
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule
